seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter; the generator end of the serial sequence-detector path. It takes a parallel pattern, a length and a repeat count. It shifts the pattern out MSB-first, one bit per clock, with a valid strobe, idle gaps between repetitions and a done pulse. It drives stimulus or link data into the team's serial sequence-detector FSMs.

Parameters:
PAT_W, 8, maximum pattern width in bits (2..32)
CNT_W, 4, width of repeat-count input
GAP, 2, idle cycles inserted between repetitions (0 = back-to-back)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request a transmission; sampled only in IDLE
pattern  input  PAT_W  pattern bits; the low len bits are sent
len  input  $clog2(PAT_W)+1  number of bits per pass
rep  input  CNT_W  extra passes; total passes = rep+1
serial_out  output  1  serial data bit, registered
bit_valid  output  1  serial_out carries a pattern bit this cycle
busy  output  1  high from the accept edge until DONE exits
done  output  1  one-cycle pulse after the last bit of the last pass

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE; serial_out, bit_valid, busy and done are all 0 immediately; internal registers are cleared.
- Reset asserted mid-transfer aborts the transfer. No done pulse is produced.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - busy=0.
  - When start=1 at an edge: latch pattern, len and rep; set bit index = len_eff-1; move to SHIFT; set busy=1 from that edge.
- len_eff rule: len==0 or len>PAT_W saturates to PAT_W.
- SHIFT:
  - Each cycle, serial_out=pattern_latched[idx] and bit_valid=1.
  - The first bit is visible in the cycle after the accept edge.
  - idx decrements each cycle.
  - At idx==0: if passes remain, go to GAP, or straight to SHIFT with idx reloaded when GAP=0. Otherwise go to DONE.
- GAP:
  - serial_out=0, bit_valid=0 for exactly GAP cycles.
  - Then reload idx=len_eff-1, decrement the remaining-pass count, and go to SHIFT.
- DONE:
  - done=1, busy=1, bit_valid=0 for one cycle.
  - Next state is IDLE.
  - start is ignored in DONE and in all non-IDLE states. A held start retriggers only once back in IDLE, so there is at least one IDLE cycle between transfers.
- Latency and duration:
  - start edge to first valid bit: 1 cycle.
  - Total busy cycles = (rep+1)*len_eff + rep*GAP + 1.
- Inputs pattern, len and rep may change freely while busy; the latched copies are used.
- rep at maximum (2^CNT_W-1) must not overflow; the pass counter is CNT_W bits counting down to 0.

Optional Feature:
SEQ_GEN_PARITY_EN
- Defined: after the len_eff bits of each pass, one extra bit_valid cycle carries the even-parity bit of the transmitted bits.
  - A PARITY state is inserted between SHIFT and GAP/DONE.
  - Busy cycles increase by rep+1.
- Undefined: no PARITY state and no parity logic; timing is exactly as above.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding localparams (IDLE=0, SHIFT=1, GAP=2, DONE=3, PARITY=4).
  - the LEN_W width constant function.
- The team's sequence detectors reuse the same package.
- One natural sub-module, seq_piso_reg: a loadable parallel-in serial-out register with bit index and load/shift enables. The FSM and counters stay in the top.

Test Plan:
- pattern=8'h03, len=2, rep=0, GAP=2, single start pulse -> serial_out 1,1 with bit_valid on cycles 1-2 after accept; done pulse on cycle 3; busy high 3 cycles.
- pattern=8'hA5, len=8, rep=2 -> three passes of 1010_0101, each separated by 2 cycles with bit_valid=0; done after 8*3+2*2=28 cycles.
- len=0 and len=12 with PAT_W=8 -> both send all 8 bits (saturation).
- start held high continuously -> transfers separated by exactly one IDLE cycle; pattern changes mid-transfer do not alter the transmitted bits.
- reset_n pulled low on the 4th bit -> outputs go to 0 asynchronously; no done pulse; a new start after release is accepted normally.
- Loopback into the team's "11" detector: pattern=8'b0110_1100, len=8, rep=0 -> detector flags at the second 1 of each pair; with SEQ_GEN_PARITY_EN defined, a 9th bit of 0 is observed.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and detector FSMs:
// state encoding and the length-field width helper.
package seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_SHIFT  = S_SHIFT,
    ST_GAP    = S_GAP,
    ST_DONE   = S_DONE,
    ST_PARITY = S_PARITY
  } seq_state_t;

  // Width of a length field that can express every value 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_piso_reg.sv
// Loadable parallel-in serial-out register with a down-counting bit index.
// The serial output is registered and returns to 0 when no action is requested.
module seq_piso_reg
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LW    = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic             put_en,
  input  logic             put_bit,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len_eff,
  output logic             sout,
  output logic             last
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    load_idx;
  logic [IW-1:0]    first_idx;
  logic [IW-1:0]    next_idx;

  assign load_idx  = IW'(len_eff - LW'(1));
  assign first_idx = IW'(len_q - LW'(1));
  assign next_idx  = idx - IW'(1);
  assign last      = (idx == '0);

  // idx always names the bit currently on sout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      len_q <= '0;
      idx   <= '0;
      sout  <= 1'b0;
    end else if (load) begin
      pat_q <= pattern;
      len_q <= len_eff;
      idx   <= load_idx;
      sout  <= pattern[load_idx];
    end else if (reload) begin
      idx  <= first_idx;
      sout <= pat_q[first_idx];
    end else if (shift) begin
      idx  <= next_idx;
      sout <= pat_q[next_idx];
    end else if (put_en) begin
      sout <= put_bit;
    end else begin
      sout <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: MSB-first passes with idle gaps and a done pulse.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after every pass.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PAT_W-1:0]        pattern,
  input  logic [len_w(PAT_W)-1:0] len,
  input  logic [CNT_W-1:0]        rep,
  output logic                    serial_out,
  output logic                    bit_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int LW = len_w(PAT_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  seq_state_t       state;
  logic [CNT_W-1:0] pass_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [LW-1:0]    len_eff;
  logic             load, reload, shift, put_en, put_bit;
  logic             last, more, pass_end;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q;
`endif

  assign len_eff = (len == '0 || len > LW'(PAT_W)) ? LW'(PAT_W) : len;
  assign more    = (pass_cnt != '0);

  // Datapath strobes decoded from the FSM state.
  always_comb begin
    load    = (state == ST_IDLE) && start;
    shift   = (state == ST_SHIFT) && !last;
`ifdef SEQ_GEN_PARITY_EN
    pass_end = (state == ST_PARITY);
    put_en   = (state == ST_SHIFT) && last;
    put_bit  = par_q ^ serial_out;
`else
    pass_end = (state == ST_SHIFT) && last;
    put_en   = 1'b0;
    put_bit  = 1'b0;
`endif
    reload  = (pass_end && more && GAP == 0) || (state == ST_GAP && gap_cnt == '0);
  end

  seq_piso_reg #(.PAT_W(PAT_W), .LW(LW)) u_piso (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .reload  (reload),
    .shift   (shift),
    .put_en  (put_en),
    .put_bit (put_bit),
    .pattern (pattern),
    .len_eff (len_eff),
    .sout    (serial_out),
    .last    (last)
  );

  // End of a pass decides between another pass (with or without a gap) and DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pass_cnt  <= '0;
      gap_cnt   <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (pass_end) begin
`ifdef SEQ_GEN_PARITY_EN
      par_q <= 1'b0;
`endif
      if (!more) begin
        state     <= ST_DONE;
        done      <= 1'b1;
        bit_valid <= 1'b0;
      end else if (GAP == 0) begin
        state     <= ST_SHIFT;
        pass_cnt  <= pass_cnt - CNT_W'(1);
        bit_valid <= 1'b1;
      end else begin
        state     <= ST_GAP;
        gap_cnt   <= GW'(GAP - 1);
        bit_valid <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT;
            pass_cnt  <= rep;
            busy      <= 1'b1;
            bit_valid <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            par_q     <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
          par_q <= par_q ^ serial_out;
          if (last) state <= ST_PARITY;
`endif
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state     <= ST_SHIFT;
            pass_cnt  <= pass_cnt - CNT_W'(1);
            bit_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: a pattern-level model queues expected
// bits and busy lengths, and a negedge monitor compares as the DUT presents them.
module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(PAT_W) + 1;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LW-1:0]    len = '0;
  logic [CNT_W-1:0] rep = '0;
  logic             serial_out, bit_valid, busy, done;

  int   checks = 0;
  int   errors = 0;
  int   busyCnt = 0;
  logic expBits[$];
  int   expBusy[$];

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .rep        (rep),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int lenEff(input int l);
    return (l == 0 || l > PAT_W) ? PAT_W : l;
  endfunction

  // Expected stream: rep+1 passes of the low len_eff bits, MSB first.
  task automatic pushModel(input logic [PAT_W-1:0] p, input int l, input int r);
    int   n;
    logic par;
    n = lenEff(l);
    for (int pass = 0; pass <= r; pass++) begin
      par = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        expBits.push_back(p[i]);
        par = par ^ p[i];
      end
      if (PBITS == 1) expBits.push_back(par);
    end
    expBusy.push_back((r + 1) * (n + PBITS) + r * GAP + 1);
  endtask

  task automatic waitDone(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput("done_seen", int'(done), 1);
  endtask

  task automatic applyStimulus(input logic [PAT_W-1:0] p, input int l, input int r);
    @(negedge clk);
    pattern = p;
    len     = LW'(l);
    rep     = CNT_W'(r);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pushModel(p, l, r);
    pattern = PAT_W'($urandom);
    len     = LW'($urandom);
    rep     = CNT_W'($urandom);
    checkOutput("busy_after_accept", int'(busy), 1);
    waitDone(600);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (bit_valid) begin
        if (expBits.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bit actual=%0d expected=none", serial_out);
        end else begin
          checkOutput("serial_out", int'(serial_out), int'(expBits.pop_front()));
        end
      end
      if (done) begin
        checkOutput("done_bit_valid", int'(bit_valid), 0);
        if (expBusy.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0");
        end else begin
          checkOutput("busy_cycles", busyCnt, expBusy.pop_front());
        end
      end
      if (!busy) busyCnt = 0;
    end
  end

  initial begin
    logic [PAT_W-1:0] pa, pb;

    #12;
    checkOutput("reset_serial_out", int'(serial_out), 0);
    checkOutput("reset_bit_valid", int'(bit_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(8'h03, 2, 0);
    applyStimulus(8'hA5, 8, 2);
    applyStimulus(PAT_W'($urandom), 0, 0);
    applyStimulus(PAT_W'($urandom), 12, 0);
    applyStimulus(8'b0110_1100, 8, 0);
    applyStimulus(PAT_W'($urandom), 8, 15);
    for (int t = 0; t < 10; t++)
      applyStimulus(PAT_W'($urandom), $urandom_range(0, 15), $urandom_range(0, 3));

    // Held start: one IDLE cycle between transfers, each using its latched pattern.
    pa = PAT_W'($urandom);
    pb = ~pa;
    @(negedge clk);
    pattern = pa;
    len     = LW'(8);
    rep     = '0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    pushModel(pa, 8, 0);
    pattern = pb;
    waitDone(100);
    @(negedge clk);
    checkOutput("idle_between_held", int'(busy), 0);
    @(posedge clk);
    #1;
    checkOutput("held_retrigger", int'(busy), 1);
    pushModel(pb, 8, 0);
    start   = 1'b0;
    pattern = PAT_W'($urandom);
    waitDone(100);

    // Asynchronous abort on the 4th bit, then a normal transfer.
    @(negedge clk);
    pattern = PAT_W'($urandom);
    len     = LW'(8);
    rep     = CNT_W'(1);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pushModel(pattern, 8, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_serial_out", int'(serial_out), 0);
    checkOutput("abort_bit_valid", int'(bit_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    expBits.delete();
    expBusy.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_abort_idle", int'(busy), 0);
    applyStimulus(8'h5A, 8, 1);

    repeat (4) @(negedge clk);
    checkOutput("bits_left", expBits.size(), 0);
    checkOutput("dones_left", expBusy.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
